// File: rtl/result_wb_pkg.sv
// Shared types and defaults for the result writeback stage of the 4-lane MAC ALU.
package result_wb_pkg;

    localparam int LANES      = 4;
    localparam int IN_W_DEF   = 18;
    localparam int ADDR_W_DEF = 4;

    typedef enum logic {
        WB_IDLE  = 1'b0,
        WB_WRITE = 1'b1
    } wb_state_e;

    // Lane 0 holds mu1, lane 3 holds mu4.
    typedef logic [LANES-1:0][IN_W_DEF-1:0] bundle_t;

endpackage

// File: rtl/result_writeback_if.sv
// Signal bundle between the MAC ALU, the result writeback stage and the result RAM.
interface result_writeback_if
    import result_wb_pkg::*;
#(
    parameter int IN_W   = IN_W_DEF,
    parameter int OUT_W  = IN_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);

    logic [IN_W-1:0]   mu1;
    logic [IN_W-1:0]   mu2;
    logic [IN_W-1:0]   mu3;
    logic [IN_W-1:0]   mu4;
    logic              web;
    logic              alu_done;
    logic              ram_ready;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [OUT_W-1:0]  ram_wdata;
    logic              wb_busy;
    logic              wb_done;
    logic              overflow;

    modport master (
        output mu1, mu2, mu3, mu4, web, alu_done, ram_ready,
        input  ram_we, ram_addr, ram_wdata, wb_busy, wb_done, overflow
    );

    modport slave (
        input  mu1, mu2, mu3, mu4, web, alu_done, ram_ready,
        output ram_we, ram_addr, ram_wdata, wb_busy, wb_done, overflow
    );

endinterface

// File: rtl/result_fifo2.sv
// Two-entry bundle FIFO; a pop in the same cycle frees the slot for a push even when full.
module result_fifo2 #(
    parameter type bundle_t = result_wb_pkg::bundle_t
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  logic    pop,
    input  bundle_t din,
    output logic    full,
    output logic    empty,
    output bundle_t head,
    output bundle_t head_nxt,
    output logic    empty_nxt
);

    bundle_t    slot0_q, slot0_d;
    bundle_t    slot1_q, slot1_d;
    logic [1:0] count_q, count_d;
    logic       do_pop, do_push;

    always_comb begin
        do_pop  = pop && (count_q != 2'd0);
        do_push = push && ((count_q != 2'd2) || do_pop);
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        if (do_pop) begin
            slot0_d = slot1_q;
            count_d = count_q - 2'd1;
        end
        if (do_push) begin
            if (count_d == 2'd0) begin
                slot0_d = din;
            end else begin
                slot1_d = din;
            end
            count_d = count_d + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

    assign full      = (count_q == 2'd2);
    assign empty     = (count_q == 2'd0);
    assign head      = slot0_q;
    assign head_nxt  = slot0_d;
    assign empty_nxt = (count_d == 2'd0);

endmodule

// File: rtl/result_writeback.sv
// Captures 4-lane ALU result bundles and serialises them, one word per cycle, into the result RAM.
//   state    | meaning
//   WB_IDLE  | FIFO empty, no write presented
//   WB_WRITE | presenting lane lane_q of the FIFO head to the RAM
module result_writeback
    import result_wb_pkg::*;
#(
    parameter int IN_W   = IN_W_DEF,
    parameter int OUT_W  = IN_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input logic               clk,
    input logic               rst,
    result_writeback_if.slave bus
);

    typedef logic [LANES-1:0][IN_W-1:0] lane_bundle_t;

    lane_bundle_t      cap_bundle, head, head_nxt, src;
    logic              full, empty, empty_nxt;
    logic              push, pop, accept, drop, complete;
    wb_state_e         state_q, state_d;
    logic [1:0]        lane_q, lane_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [OUT_W-1:0]  wdata_q, wdata_d, sat_word;
    logic [IN_W-1:0]   lane_word;
    logic              we_q, we_d, busy_q, busy_d, done_q, done_d;
    logic              ovf_q, ovf_d, pend_q, pend_d;

    assign cap_bundle = {bus.mu4, bus.mu3, bus.mu2, bus.mu1};
    assign push       = bus.web;
    assign accept     = we_q && bus.ram_ready;
    assign pop        = accept && (lane_q == 2'd3);
    assign drop       = push && full && !pop;
    assign lane_d     = accept ? lane_q + 2'd1 : lane_q;

    result_fifo2 #(.bundle_t(lane_bundle_t)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .din       (cap_bundle),
        .full      (full),
        .empty     (empty),
        .head      (head),
        .head_nxt  (head_nxt),
        .empty_nxt (empty_nxt)
    );

    // The head only changes on a pop or on the first push into an empty FIFO.
    assign src       = (pop || empty) ? head_nxt : head;
    assign lane_word = src[lane_d];

    generate
        if (OUT_W >= IN_W) begin : g_zext
            assign sat_word = OUT_W'(lane_word);
        end else begin : g_sat
            assign sat_word = (|lane_word[IN_W-1:OUT_W]) ? '1 : lane_word[OUT_W-1:0];
        end
    endgenerate

    always_comb begin
        complete = pend_q && empty && (state_q == WB_IDLE);
        state_d  = empty_nxt ? WB_IDLE : WB_WRITE;
        we_d     = (state_d == WB_WRITE);
        wdata_d  = we_d ? sat_word : '0;
        busy_d   = !empty_nxt || (state_d == WB_WRITE);
        done_d   = complete;
        pend_d   = bus.alu_done || (pend_q && !complete);
        ovf_d    = ovf_q || drop;
        addr_d   = addr_q;
        if (complete) begin
            addr_d = '0;
        end else if (accept) begin
            addr_d = addr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WB_IDLE;
            lane_q  <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            pend_q  <= pend_d;
        end
    end

    assign bus.ram_we    = we_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.wb_busy   = busy_q;
    assign bus.wb_done   = done_q;
    assign bus.overflow  = ovf_q;

endmodule
